// File: rtl/eh2_pkg.sv
// Shared types for the DCCM store buffer.
//   STBUF_DEPTH  : default number of store-buffer entries
//   STBUF_ADDR_W : DCCM byte address width (DCCM_BITS)
//   STBUF_DATA_W : DCCM word + ECC width (DCCM_FDATA_WIDTH)
//   eh2_stbuf_entry_t : one buffered store {valid, addr, data}
package eh2_pkg;

  localparam int STBUF_DEPTH  = 4;
  localparam int STBUF_ADDR_W = 16;
  localparam int STBUF_DATA_W = 39;

  typedef struct packed {
    logic                    valid;
    logic [STBUF_ADDR_W-1:0] addr;
    logic [STBUF_DATA_W-1:0] data;
  } eh2_stbuf_entry_t;

endpackage

// File: rtl/eh2_stbuf_fwd_sel.sv
// Store-to-load forward select. Compares the load word index against every
// valid entry and returns the data of the youngest match (closest to
// wr_ptr-1 walking backward).
//   ents    : entry array (registered state of the buffer)
//   wr_ptr  : next write slot; wr_ptr-1 is the youngest entry
//   ld_addr : load byte address
//   hit     : some valid entry holds the load's word
//   data    : youngest matching entry data, 0 on miss
module eh2_stbuf_fwd_sel import eh2_pkg::*; #(
  parameter  int DEPTH  = STBUF_DEPTH,
  parameter  int ADDR_W = STBUF_ADDR_W,
  parameter  int DATA_W = STBUF_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  eh2_stbuf_entry_t  ents [DEPTH],
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = ents[i].valid &&
                      (ents[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
  end

  // Walk from oldest age (wr_ptr-DEPTH == wr_ptr) to youngest (wr_ptr-1);
  // the last match written wins, so the youngest entry has priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int a = DEPTH; a >= 1; a--) begin
      idx = wr_ptr - PTR_W'(a);
      if (match[idx]) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/eh2_dccm_stbuf.sv
// DCCM store buffer. Holds committed LSU stores in an in-order FIFO and
// drains one per cycle into the DCCM write port whenever the read port is
// free, the buffer is full, or a flush is requested. Loads hitting a
// pending entry get forwarded data.
//   clk, rst          : clock, async active-high reset
//   st_valid/st_ready : store handshake; st_addr/st_data store payload
//   ld_req/ld_addr    : load using the read port this cycle
//   ld_stall          : load lost the read port to a forced drain
//   fwd_hit/fwd_data  : forwarding result for ld_addr
//   dccm_wren/_addr/_data : DCCM write (registered by the wrapper)
//   flush_req         : drain regardless of loads
//   empty/count       : occupancy
module eh2_dccm_stbuf import eh2_pkg::*; #(
  parameter  int DEPTH  = STBUF_DEPTH,
  parameter  int ADDR_W = STBUF_ADDR_W,
  parameter  int DATA_W = STBUF_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_stall,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              dccm_wren,
  output logic [ADDR_W-1:0] dccm_wr_addr,
  output logic [DATA_W-1:0] dccm_wr_data,
  input  logic              flush_req,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  eh2_stbuf_entry_t ents_q [DEPTH];
  eh2_stbuf_entry_t ents_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, enq, drain;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = !full;
  // A full buffer refuses stores even while draining, so enq never aliases
  // the head slot being freed.
  assign enq      = st_valid && !full;
  assign drain    = !empty && (!ld_req || full || flush_req);
  assign ld_stall = ld_req && drain;

  assign dccm_wren    = drain;
  assign dccm_wr_addr = drain ? ents_q[rd_ptr_q].addr : '0;
  assign dccm_wr_data = drain ? ents_q[rd_ptr_q].data : '0;

  always_comb begin
    ents_d   = ents_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      ents_d[wr_ptr_q] = '{valid: 1'b1, addr: st_addr, data: st_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      ents_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d               = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ents_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ents_q   <= ents_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Forwarding looks only at registered entries: a store enqueueing this
  // cycle is not visible, while the head being drained still is.
  eh2_stbuf_fwd_sel #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fwd_sel (
    .ents   (ents_q),
    .wr_ptr (wr_ptr_q),
    .ld_addr(ld_addr),
    .hit    (fwd_hit),
    .data   (fwd_data)
  );

endmodule

// File: tb/tb_eh2_dccm_stbuf.sv
module tb_eh2_dccm_stbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [15:0] st_addr = '0;
  logic [38:0] st_data = '0;
  logic        ld_req = 1'b0;
  logic [15:0] ld_addr = '0;
  logic        ld_stall, fwd_hit;
  logic [38:0] fwd_data;
  logic        dccm_wren;
  logic [15:0] dccm_wr_addr;
  logic [38:0] dccm_wr_data;
  logic        flush_req = 1'b0;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  eh2_dccm_stbuf dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .flush_req(flush_req), .empty(empty), .count(count)
  );

  typedef struct packed { logic [15:0] a; logic [38:0] d; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Scoreboard: every DCCM write must match the oldest outstanding store.
  always @(negedge clk) begin
    if (mon_en && !rst && dccm_wren) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%h data=%h required=no write", dccm_wr_addr, dccm_wr_data);
      end else begin
        mon_e = sb.pop_front();
        if (dccm_wr_addr !== mon_e.a || dccm_wr_data !== mon_e.d) begin
          errors++;
          $display("FAIL sb_write_order addr=%h data=%h required addr=%h data=%h",
                   dccm_wr_addr, dccm_wr_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [38:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    sb.push_back('{a: a, d: d});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty got=%b want=1", empty); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rst_count got=%0d want=0", count); end
    checks++; if (st_ready !== 1'b1)  begin errors++; $display("FAIL rst_st_ready got=%b want=1", st_ready); end
    checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b want=0", dccm_wren); end
    checks++; if (fwd_hit !== 1'b0)   begin errors++; $display("FAIL rst_fwd_hit got=%b want=0", fwd_hit); end
    checks++; if (ld_stall !== 1'b0)  begin errors++; $display("FAIL rst_ld_stall got=%b want=0", ld_stall); end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    tick();
    ld_req = 1'b0;
    push(16'h0104, {7'h2A, 32'h12345678});
    @(negedge clk);
    checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL single_no_early_wr got=%b want=0", dccm_wren); end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (dccm_wren !== 1'b1) begin errors++; $display("FAIL single_wren got=%b want=1", dccm_wren); end
    checks++; if (dccm_wr_addr !== 16'h0104) begin errors++; $display("FAIL single_addr got=%h want=0104", dccm_wr_addr); end
    tick();
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b want=1", empty); end
  endtask

  task automatic test_full();
    tick();
    ld_req = 1'b1; ld_addr = 16'h0F00;
    for (int i = 0; i < 4; i++) begin
      push(16'h0300 + 16'(4*i), 39'(64'hA000 + i));
      if (i < 3) tick();
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd4)     begin errors++; $display("FAIL full_count got=%0d want=4", count); end
    checks++; if (st_ready !== 1'b0)  begin errors++; $display("FAIL full_st_ready got=%b want=0", st_ready); end
    checks++; if (dccm_wren !== 1'b1) begin errors++; $display("FAIL full_forced_wren got=%b want=1", dccm_wren); end
    checks++; if (ld_stall !== 1'b1)  begin errors++; $display("FAIL full_ld_stall got=%b want=1", ld_stall); end
    checks++; if (fwd_hit !== 1'b0)   begin errors++; $display("FAIL full_fwd_miss got=%b want=0", fwd_hit); end
    tick();
    @(negedge clk);
    checks++; if (count !== 3'd3)     begin errors++; $display("FAIL full_after_count got=%0d want=3", count); end
    checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL full_after_wren got=%b want=0", dccm_wren); end
    checks++; if (st_ready !== 1'b1)  begin errors++; $display("FAIL full_after_ready got=%b want=1", st_ready); end
    ld_req = 1'b0;
    for (int k = 0; k < 20 && empty !== 1'b1; k++) tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_timeout empty=%b want=1", empty); end
  endtask

  task automatic test_fwd();
    tick();
    ld_req = 1'b1; ld_addr = 16'h0200;
    push(16'h0200, 39'h0A_AAAA_AAAA);
    tick();
    push(16'h0202, 39'h0B_BBBB_BBBB);
    @(negedge clk);
    // B is only being offered: A must still be the forwarded value.
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 39'h0A_AAAA_AAAA)
      begin errors++; $display("FAIL fwd_same_cycle hit=%b data=%h want 1/%h", fwd_hit, fwd_data, 39'h0A_AAAA_AAAA); end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 39'h0B_BBBB_BBBB)
      begin errors++; $display("FAIL fwd_youngest hit=%b data=%h want 1/%h", fwd_hit, fwd_data, 39'h0B_BBBB_BBBB); end
    ld_addr = 16'h0204;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 39'h0)
      begin errors++; $display("FAIL fwd_miss hit=%b data=%h want 0/0", fwd_hit, fwd_data); end
    tick();
    ld_req = 1'b0; ld_addr = 16'h0200;
    @(negedge clk);
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 39'h0B_BBBB_BBBB || dccm_wren !== 1'b1)
      begin errors++; $display("FAIL fwd_while_drain hit=%b data=%h wren=%b want 1/%h/1", fwd_hit, fwd_data, dccm_wren, 39'h0B_BBBB_BBBB); end
    tick();
    @(negedge clk);
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 39'h0B_BBBB_BBBB || count !== 3'd1)
      begin errors++; $display("FAIL fwd_head_drain hit=%b data=%h count=%0d want 1/%h/1", fwd_hit, fwd_data, count, 39'h0B_BBBB_BBBB); end
    for (int k = 0; k < 20 && empty !== 1'b1; k++) tick();
    checks++; if (empty !== 1'b1 || fwd_hit !== 1'b0)
      begin errors++; $display("FAIL fwd_drain_end empty=%b hit=%b want 1/0", empty, fwd_hit); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      tick();
      ld_req = i[0];
      push(16'h0400 + 16'(4*i), 39'($urandom));
    end
    tick();
    st_valid = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < 20 && empty !== 1'b1; k++) tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_timeout empty=%b want=1", empty); end
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_lost_entries outstanding=%0d want=0", sb.size()); end
  endtask

  task automatic test_flush();
    tick();
    ld_req = 1'b1; ld_addr = 16'h0F00;
    for (int i = 0; i < 3; i++) begin
      push(16'h0500 + 16'(4*i), 39'(64'h5500 + i));
      tick();
    end
    st_valid = 1'b0; flush_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dccm_wren !== 1'b1 || ld_stall !== 1'b1 || count !== 3'(3-k))
        begin errors++; $display("FAIL flush_drain_%0d wren=%b stall=%b count=%0d want 1/1/%0d", k, dccm_wren, ld_stall, count, 3-k); end
      tick();
    end
    @(negedge clk);
    checks++; if (empty !== 1'b1 || dccm_wren !== 1'b0)
      begin errors++; $display("FAIL flush_empty empty=%b wren=%b want 1/0", empty, dccm_wren); end
    flush_req = 1'b0;
  endtask

  task automatic test_flush_reset();
    tick();
    ld_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(16'h0600 + 16'(4*i), 39'(64'h6600 + i));
      tick();
    end
    st_valid = 1'b0; flush_req = 1'b1;
    @(negedge clk);
    checks++; if (dccm_wren !== 1'b1) begin errors++; $display("FAIL rstflush_first wren=%b want=1", dccm_wren); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || dccm_wren !== 1'b0)
      begin errors++; $display("FAIL rstflush_clear count=%0d empty=%b wren=%b want 0/1/0", count, empty, dccm_wren); end
    sb.delete();
    tick();
    rst = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL rstflush_no_wr_%0d wren=%b want=0", k, dccm_wren); end
      tick();
    end
    flush_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_fwd();
    test_wrap();
    test_flush();
    test_flush_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
